spi_ram_ctrl: RTL and testbench

Single-port RAM with command decoder, directly downstream of the SPI slave. Consumes the slave's 10-bit rx_data/rx_valid words, decodes the 2-bit command prefix, and performs address latching, writes and reads. Returns read data to the slave on dout/tx_valid for serialisation onto MISO.

---
 rtl/spi_ram_ctrl.sv | 130 +++++++++++++
 tb/tb_spi_ram_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Command-decoding single-port RAM behind the SPI slave: address latch, write, read-back.
// Optional RAM_AUTO_INC_EN: post-increment wr/rd address after each successful data command.
module spi_ram_ctrl #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] din,
   input  logic       rx_valid,
   output logic [7:0] dout,
   output logic       tx_valid,
   output logic       wr_err,
   output logic       rd_err
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t               state_q, state_d;
   logic [7:0]           mem [MEM_DEPTH];
   logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
   logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
   logic                 wr_addr_ok_q, wr_addr_ok_d;
   logic                 rd_addr_ok_q, rd_addr_ok_d;
   logic                 rx_valid_dly_q, rx_valid_dly_d;
   logic [7:0]           dout_q, dout_d;
   logic                 tx_valid_q, tx_valid_d;
   logic                 wr_err_q, wr_err_d;
   logic                 rd_err_q, rd_err_d;
   logic                 accept;
   logic                 exec;
   logic                 mem_we;

   always_comb begin
      state_d        = IDLE;
      wr_addr_d      = wr_addr_q;
      rd_addr_d      = rd_addr_q;
      wr_addr_ok_d   = wr_addr_ok_q;
      rd_addr_ok_d   = rd_addr_ok_q;
      rx_valid_dly_d = rx_valid;
      dout_d         = dout_q;
      tx_valid_d     = tx_valid_q;
      wr_err_d       = 1'b0;
      rd_err_d       = 1'b0;
      mem_we         = 1'b0;
      // Only a rising edge of the level-valid starts a command.
      accept         = rx_valid & ~rx_valid_dly_q;
      exec           = accept && (state_q == IDLE);

      if (exec) begin
         state_d    = EXEC;
         tx_valid_d = 1'b0;
         case (din[9:8])
            2'b00: begin
               wr_addr_d    = din[ADDR_SIZE-1:0];
               wr_addr_ok_d = 1'b1;
            end
            2'b01: begin
               if (wr_addr_ok_q) begin
                  mem_we = 1'b1;
`ifdef RAM_AUTO_INC_EN
                  wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
`else
                  wr_addr_d = wr_addr_q;
`endif
               end else begin
                  wr_err_d = 1'b1;
               end
            end
            2'b10: begin
               rd_addr_d    = din[ADDR_SIZE-1:0];
               rd_addr_ok_d = 1'b1;
            end
            default: begin
               if (rd_addr_ok_q) begin
                  dout_d     = mem[rd_addr_q];
                  tx_valid_d = 1'b1;
`ifdef RAM_AUTO_INC_EN
                  rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
`else
                  rd_addr_d = rd_addr_q;
`endif
               end else begin
                  rd_err_d   = 1'b1;
                  tx_valid_d = tx_valid_q;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         wr_addr_q      <= '0;
         rd_addr_q      <= '0;
         wr_addr_ok_q   <= 1'b0;
         rd_addr_ok_q   <= 1'b0;
         rx_valid_dly_q <= 1'b0;
         dout_q         <= 8'h00;
         tx_valid_q     <= 1'b0;
         wr_err_q       <= 1'b0;
         rd_err_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_addr_q      <= wr_addr_d;
         rd_addr_q      <= rd_addr_d;
         wr_addr_ok_q   <= wr_addr_ok_d;
         rd_addr_ok_q   <= rd_addr_ok_d;
         rx_valid_dly_q <= rx_valid_dly_d;
         dout_q         <= dout_d;
         tx_valid_q     <= tx_valid_d;
         wr_err_q       <= wr_err_d;
         rd_err_q       <= rd_err_d;
      end
   end

   // Storage is deliberately not reset; reset only blocks a coincident write.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem[wr_addr_q] <= din[7:0];
      end
   end

   assign dout     = dout_q;
   assign tx_valid = tx_valid_q;
   assign wr_err   = wr_err_q;
   assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: read data is queued when a read is issued and
// compared when the DUT presents it.
module tb_spi_ram_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [9:0] din = 10'h000;
   logic       rx_valid = 1'b0;
   logic [7:0] dout;
   logic       tx_valid;
   logic       wr_err;
   logic       rd_err;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;
   logic       rd_pend = 1'b0;

   logic [7:0] m_mem [256];
   logic [7:0] m_wa = 8'h00;
   logic [7:0] m_ra = 8'h00;
   logic       m_wok = 1'b0;
   logic       m_rok = 1'b0;

   always #5 clk = ~clk;

   spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .rx_valid (rx_valid),
      .dout     (dout),
      .tx_valid (tx_valid),
      .wr_err   (wr_err),
      .rd_err   (rd_err)
   );

   // Read-data monitor: pops the scoreboard one cycle after each successful read accept.
   always @(posedge clk) begin
      if (rd_pend) begin
         #1;
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_data: read returned dout=%h but scoreboard empty", dout);
         end else begin
            exp_v = exp_q.pop_front();
            if (dout !== exp_v || tx_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL rd_data: dout=%h tx_valid=%b, expected dout=%h tx_valid=1",
                        dout, tx_valid, exp_v);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drives one command on a fresh rx_valid rising edge, updates the reference model,
   // and returns 1 ns after the accepting clock edge with rx_valid still high.
   task automatic send(input logic [9:0] w);
      @(negedge clk);
      din      = w;
      rx_valid = 1'b1;
      case (w[9:8])
         2'b00: begin m_wa = w[7:0]; m_wok = 1'b1; end
         2'b01: if (m_wok) begin
            m_mem[m_wa] = w[7:0];
`ifdef RAM_AUTO_INC_EN
            m_wa = m_wa + 8'h01;
`endif
         end
         2'b10: begin m_ra = w[7:0]; m_rok = 1'b1; end
         default: if (m_rok) begin
            exp_q.push_back(m_mem[m_ra]);
            rd_pend = 1'b1;
`ifdef RAM_AUTO_INC_EN
            m_ra = m_ra + 8'h01;
`endif
         end
      endcase
      @(posedge clk);
      #1;
      rd_pend = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         rx_valid = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      repeat (n) @(posedge clk);
      m_wa  = 8'h00;
      m_ra  = 8'h00;
      m_wok = 1'b0;
      m_rok = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      do_reset(2);
      n_chk += 4;
      if (dout !== 8'h00)  begin n_fail++; $display("FAIL reset_dout: got %h want 00", dout); end
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
      if (wr_err !== 1'b0) begin n_fail++; $display("FAIL reset_wr_err: got %b want 0", wr_err); end
      if (rd_err !== 1'b0) begin n_fail++; $display("FAIL reset_rd_err: got %b want 0", rd_err); end
   endtask

   task automatic test_basic;
      send(10'h0_0A); idle(1);
      send(10'h1_5C);
      n_chk++;
      if (wr_err !== 1'b0) begin n_fail++; $display("FAIL basic_wr_err: got %b want 0", wr_err); end
      idle(1);
      send(10'h2_0A); idle(1);
      send(10'h3_00); idle(1);
      repeat (3) begin
         idle(1);
         n_chk++;
         if (tx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_tx_hold: got %b want 1", tx_valid); end
      end
      send(10'h0_10);
      n_chk += 2;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_tx_drop: got %b want 0", tx_valid); end
      if (dout !== 8'h5C) begin n_fail++; $display("FAIL basic_dout_hold: got %h want 5c", dout); end
      idle(1);
   endtask

   task automatic test_hold;
      send(10'h0_03); idle(1);
      send(10'h1_AA);
      repeat (11) begin
         @(posedge clk); #1;
         n_chk++;
         if (wr_err !== 1'b0 || rd_err !== 1'b0) begin
            n_fail++; $display("FAIL hold_no_repeat: wr_err=%b rd_err=%b want 0 0", wr_err, rd_err);
         end
      end
      idle(1);
      send(10'h2_03); idle(1);
      send(10'h3_00); idle(1);
   endtask

   task automatic test_errors;
      send(10'h0_00); idle(1);
      send(10'h1_77); idle(1);
      do_reset(1);
      send(10'h3_00);
      n_chk += 2;
      if (rd_err !== 1'b1) begin n_fail++; $display("FAIL err_rd_pulse: got %b want 1", rd_err); end
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL err_rd_tx: got %b want 0", tx_valid); end
      repeat (3) begin
         @(posedge clk); #1;
         n_chk++;
         if (rd_err !== 1'b0) begin n_fail++; $display("FAIL err_rd_once: got %b want 0", rd_err); end
      end
      idle(1);
      send(10'h1_11);
      n_chk++;
      if (wr_err !== 1'b1) begin n_fail++; $display("FAIL err_wr_pulse: got %b want 1", wr_err); end
      repeat (3) begin
         @(posedge clk); #1;
         n_chk++;
         if (wr_err !== 1'b0) begin n_fail++; $display("FAIL err_wr_once: got %b want 0", wr_err); end
      end
      idle(1);
      send(10'h2_00); idle(1);
      send(10'h3_00); idle(1);
   endtask

   task automatic test_back_to_back;
      send(10'h0_21); idle(1);
      send(10'h1_3C); idle(1);
      send(10'h0_22); idle(1);
      send(10'h1_4D); idle(1);
      send(10'h2_21); idle(1);
      send(10'h3_00); idle(1);
      send(10'h2_22); idle(1);
      send(10'h3_00); idle(1);
   endtask

   task automatic test_reset_mid_read;
      send(10'h2_21); idle(1);
      send(10'h3_00);
      do_reset(1);
      n_chk += 2;
      if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 0", tx_valid); end
      if (dout !== 8'h00) begin n_fail++; $display("FAIL rst_mid_dout: got %h want 00", dout); end
      send(10'h2_21); idle(1);
      send(10'h3_00); idle(1);
   endtask

   task automatic test_burst;
      send(10'h0_FF); idle(1);
      send(10'h1_01); idle(1);
      send(10'h1_02); idle(1);
      send(10'h2_FF); idle(1);
      send(10'h3_00); idle(1);
      send(10'h3_00); idle(1);
`ifdef RAM_AUTO_INC_EN
      send(10'h2_00); idle(1);
      send(10'h3_00); idle(1);
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_errors();
      test_back_to_back();
      test_reset_mid_read();
      test_burst();
      repeat (3) @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d reads outstanding, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
